// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_resp_sram responder.
//   XLEN / MASK_W   : data width and byte-enable width
//   state_e         : responder FSM states
//   resp_t          : response payload (data + error flag)
//   apply_byte_mask : merge new bytes into an old word under a byte mask
package mem_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } resp_t;

  // Byte lane i of the result comes from new_word when mask[i] is set, else from old_word.
  function automatic logic [XLEN-1:0] apply_byte_mask(
    input logic [XLEN-1:0]   old_word,
    input logic [XLEN-1:0]   new_word,
    input logic [MASK_W-1:0] mask
  );
    logic [XLEN-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_resp_sram_array.sv
// Word-addressed storage for mem_resp_sram.
//   clk, rst  : clock, async active-high reset (read register only; contents are never cleared)
//   acc_en    : request accepted this cycle
//   wr_en     : accepted request is a write
//   in_range  : accepted address falls inside the array
//   index     : word index of the accepted request
//   wdata     : write data
//   wmask     : write byte enables
//   rd_data   : read result captured at acceptance; 0 for writes and out-of-range requests
module mem_resp_sram_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           acc_en,
  input  logic                           wr_en,
  input  logic                           in_range,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [XLEN-1:0]                wdata,
  input  logic [MASK_W-1:0]              wmask,
  output logic [XLEN-1:0]                rd_data
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rd_data_q;
  logic [XLEN-1:0] rd_data_d;
  logic            wr_commit_c;

  assign wr_commit_c = acc_en && wr_en && in_range;

  // Read result is latched only on acceptance, so it stays stable for the whole response.
  always_comb begin
    rd_data_d = rd_data_q;
    if (acc_en) begin
      rd_data_d = (!wr_en && in_range) ? mem_q[index] : '0;
    end
  end

  // Storage is deliberately not reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (wr_commit_c) begin
      mem_q[index] <= apply_byte_mask(mem_q[index], wdata, wmask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_resp_sram.sv
// Synthesizable 64-bit memory responder: one request at a time on a valid/ready
// channel, one response LATENCY cycles after acceptance.
//   iClk, iRst        : clock, async active-high reset
//   iReqValid/oReqReady, iReqWrEn, iReqAddr, iReqData, iReqMask : request channel
//   oRespValid/iRespReady, oRespData, oRespErr                  : response channel
// Optional feature: define MEM_RESP_SRAM_TRACE_EN to print a trace line per accepted request.
module mem_resp_sram
  import mem_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned     LATENCY     = 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iReqWrEn,
  input  logic [XLEN-1:0]   iReqAddr,
  input  logic [XLEN-1:0]   iReqData,
  input  logic [MASK_W-1:0] iReqMask,
  output logic              oRespValid,
  input  logic              iRespReady,
  output logic [XLEN-1:0]   oRespData,
  output logic              oRespErr
);

  localparam int unsigned     AW         = $clog2(DEPTH_WORDS);
  localparam int unsigned     CW         = 4;
  localparam logic [XLEN-1:0] SPAN_BYTES = XLEN'(DEPTH_WORDS) << 3;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;

  logic            accept_c;
  logic            in_range_c;
  logic [XLEN-1:0] offset_c;
  logic [AW-1:0]   index_c;
  logic [XLEN-1:0] rd_data;
  resp_t           resp_c;

  // Address decode: unsigned-wrap offset from the base, word index from bits above the byte lane.
  assign offset_c   = iReqAddr - BASE_ADDR;
  assign in_range_c = (iReqAddr >= BASE_ADDR) && (offset_c < SPAN_BYTES);
  assign index_c    = offset_c[3 +: AW];

  // Ready is a registered output, so it also gates acceptance in the cycle after reset release.
  assign accept_c = (state_q == IDLE) && req_ready_q && iReqValid;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          cnt_d      = CW'(LATENCY - 1);
          resp_err_d = !in_range_c;
          state_d    = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = RESP;
      end
      RESP: begin
        if (iRespReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  mem_resp_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (iClk),
    .rst     (iRst),
    .acc_en  (accept_c),
    .wr_en   (iReqWrEn),
    .in_range(in_range_c),
    .index   (index_c),
    .wdata   (iReqData),
    .wmask   (iReqMask),
    .rd_data (rd_data)
  );

  assign resp_c     = '{data: rd_data, err: resp_err_q};
  assign oReqReady  = req_ready_q;
  assign oRespValid = resp_valid_q;
  assign oRespData  = resp_c.data;
  assign oRespErr   = resp_c.err;

`ifdef MEM_RESP_SRAM_TRACE_EN
  logic [63:0] cycle_q, cycle_d;

  assign cycle_d = cycle_q + 64'd1;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) cycle_q <= '0;
    else      cycle_q <= cycle_d;
  end

  // Trace of each accepted request.
  always_ff @(posedge iClk) begin
    if (!iRst && accept_c) begin
      $display("[%0d] %s addr=%h data=%h mask=%h in_range=%0b",
               cycle_q, iReqWrEn ? "W" : "R", iReqAddr, iReqData, iReqMask, in_range_c);
      if (!in_range_c) $display("[%0d] MEM ERR addr=%h", cycle_q, iReqAddr);
    end
  end
`endif

endmodule

// File: tb/tb_mem_resp_sram.sv
// Directed bench for mem_resp_sram: one LATENCY=1 instance (slot 0) and one LATENCY=3 instance (slot 1).
module tb_mem_resp_sram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_wr     [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_data   [2];
  logic [7:0]  req_mask   [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [63:0] resp_data  [2];
  logic        resp_err   [2];

  int n_chk  = 0;
  int n_pass = 0;

  mem_resp_sram #(.LATENCY(1)) u_lat1 (
    .iClk(clk), .iRst(rst),
    .iReqValid(req_valid[0]), .oReqReady(req_ready[0]), .iReqWrEn(req_wr[0]),
    .iReqAddr(req_addr[0]), .iReqData(req_data[0]), .iReqMask(req_mask[0]),
    .oRespValid(resp_valid[0]), .iRespReady(resp_ready[0]),
    .oRespData(resp_data[0]), .oRespErr(resp_err[0])
  );

  mem_resp_sram #(.LATENCY(3)) u_lat3 (
    .iClk(clk), .iRst(rst),
    .iReqValid(req_valid[1]), .oReqReady(req_ready[1]), .iReqWrEn(req_wr[1]),
    .iReqAddr(req_addr[1]), .iReqData(req_data[1]), .iReqMask(req_mask[1]),
    .oRespValid(resp_valid[1]), .iRespReady(resp_ready[1]),
    .oRespData(resp_data[1]), .oRespErr(resp_err[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // One full request/response on slot d. Called at a negedge; returns at a negedge with the DUT idle.
  // stall: cycles iRespReady stays low after valid rises; noise: drive a bogus write while busy.
  task automatic txn(input int d, input string tag, input logic wr, input logic [63:0] addr,
                     input logic [63:0] data, input logic [7:0] mask, input int lat,
                     input int stall, input logic noise,
                     input logic [63:0] exp_data, input logic exp_err);
    int n;
    chk({tag, ".ready"}, 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1; req_wr[d] = wr; req_addr[d] = addr;
    req_data[d]  = data; req_mask[d] = mask;
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (!resp_valid[d] && n < 20) begin
      chk({tag, ".busy"}, 64'(req_ready[d]), 64'd0);
      if (noise) begin
        req_valid[d] = 1'b1; req_wr[d] = 1'b1; req_addr[d] = addr + 64'd8;
        req_data[d]  = '1;   req_mask[d] = 8'hFF;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"},   64'(n), 64'(lat));
    chk({tag, ".valid"}, 64'(resp_valid[d]), 64'd1);
    chk({tag, ".data"},  resp_data[d], exp_data);
    chk({tag, ".err"},   64'(resp_err[d]), 64'(exp_err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, 64'(resp_valid[d]), 64'd1);
      chk({tag, ".stall_data"},  resp_data[d], exp_data);
      chk({tag, ".stall_ready"}, 64'(req_ready[d]), 64'd0);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b0;
    chk({tag, ".done_valid"}, 64'(resp_valid[d]), 64'd0);
    chk({tag, ".done_ready"}, 64'(req_ready[d]), 64'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0;
      req_data[d]  = '0;   req_mask[d] = '0; resp_ready[d] = 1'b0;
    end

    // Reset state, then release.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst.ready", 64'(req_ready[d]), 64'd0);
      chk("rst.valid", 64'(resp_valid[d]), 64'd0);
      chk("rst.data",  resp_data[d], 64'd0);
      chk("rst.err",   64'(resp_err[d]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel.ready0", 64'(req_ready[0]), 64'd1);
    chk("rel.ready1", 64'(req_ready[1]), 64'd1);

    // LATENCY=1: full write, masked write, no-op mask, reads.
    txn(0, "w_full", 1'b1, 64'h8000_0008, 64'h1122334455667788, 8'hFF, 1, 0, 1'b0, 64'd0, 1'b0);
    txn(0, "r_full", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 1, 0, 1'b0, 64'h1122334455667788, 1'b0);
    txn(0, "w_mask", 1'b1, 64'h8000_0008, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1, 0, 1'b0, 64'd0, 1'b0);
    txn(0, "r_mask", 1'b0, 64'h8000_0008, 64'd0, 8'hFF, 1, 0, 1'b0, 64'h11223344AAAAAAAA, 1'b0);
    txn(0, "w_nomask", 1'b1, 64'h8000_0008, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1, 0, 1'b0, 64'd0, 1'b0);
    txn(0, "r_nomask", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 1, 0, 1'b0, 64'h11223344AAAAAAAA, 1'b0);

    // Range boundaries.
    txn(0, "r_below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 1, 0, 1'b0, 64'd0, 1'b1);
    txn(0, "r_above", 1'b0, 64'h8000_2000, 64'd0, 8'h00, 1, 0, 1'b0, 64'd0, 1'b1);
    txn(0, "w_top",   1'b1, 64'h8000_1FF8, 64'hDEADBEEFCAFEF00D, 8'hFF, 1, 0, 1'b0, 64'd0, 1'b0);
    txn(0, "r_top",   1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 1, 0, 1'b0, 64'hDEADBEEFCAFEF00D, 1'b0);
    txn(0, "w_word0", 1'b1, 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 1, 0, 1'b0, 64'd0, 1'b0);
    txn(0, "w_oor",   1'b1, 64'h8000_2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, 0, 1'b0, 64'd0, 1'b1);
    txn(0, "r_word0", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 1, 0, 1'b0, 64'h0123456789ABCDEF, 1'b0);

    // LATENCY=3: write, then read with a 5-cycle response stall.
    txn(1, "w_l3",  1'b1, 64'h8000_0010, 64'h0102030405060708, 8'hFF, 3, 0, 1'b0, 64'd0, 1'b0);
    txn(1, "r_l3s", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 3, 5, 1'b0, 64'h0102030405060708, 1'b0);

    // Reset asserted while a read is in WAIT: the response must never appear.
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 64'h8000_0010;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("abort.wait_ready", 64'(req_ready[1]), 64'd0);
    rst = 1'b1;
    #1;
    chk("abort.async_valid", 64'(resp_valid[1]), 64'd0);
    chk("abort.async_ready", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort.no_valid", 64'(resp_valid[1]), 64'd0);
    end
    chk("abort.ready", 64'(req_ready[1]), 64'd1);
    txn(1, "r_after_rst", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 3, 0, 1'b0, 64'h0102030405060708, 1'b0);
    txn(0, "r_keep_l1",   1'b0, 64'h8000_0008, 64'd0, 8'h00, 1, 0, 1'b0, 64'h11223344AAAAAAAA, 1'b0);

    // Requests driven while busy are ignored.
    txn(1, "w_next", 1'b1, 64'h8000_0018, 64'h5555555555555555, 8'hFF, 3, 0, 1'b0, 64'd0, 1'b0);
    txn(1, "r_noise", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 3, 2, 1'b1, 64'h0102030405060708, 1'b0);
    txn(1, "r_next", 1'b0, 64'h8000_0018, 64'd0, 8'h00, 3, 0, 1'b0, 64'h5555555555555555, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_resp_sram.md
Name: mem_resp_sram

Overview:
- Synthesizable 64-bit memory responder: the target side of the CPU's instruction/load/store memory traffic.
- Replaces the simulator-backed DPI-C memory when the core is built for FPGA or for pure-RTL simulation.
- Accepts one request at a time on a valid/ready channel and returns one response after a fixed, parameterized latency.
- Storage is an internal word-addressed register array; writes are byte-masked.

Parameters:
- DEPTH_WORDS, 1024: number of 64-bit words; must be a power of two, at least 2.
- BASE_ADDR, 64'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles from request acceptance to response valid; legal range 1..15.

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iReqValid  in  1  request present.
- oReqReady  out  1  responder can accept a request.
- iReqWrEn  in  1  1 = write, 0 = read.
- iReqAddr  in  64  byte address; bits [2:0] ignored (word aligned).
- iReqData  in  64  write data.
- iReqMask  in  8  byte-enable for writes; bit i enables byte lane i.
- oRespValid  out  1  response present.
- iRespReady  in  1  consumer accepts the response.
- oRespData  out  64  read data; 0 for writes and errors.
- oRespErr  out  1  address was outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS).

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - oReqReady=0 while iRst is high, 1 on the first cycle after release.
  - oRespValid=0, oRespData=0, oRespErr=0, latency counter=0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - oReqReady=1.
  - When iReqValid&&oReqReady at a clock edge, the request is accepted. Address, write enable, data and mask are captured; the counter is loaded with LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise WAIT.
- Request side effects:
  - The write is committed to the array in the acceptance cycle, only when the address is in range.
  - A read samples the array at the acceptance edge.
- WAIT:
  - oReqReady=0; the counter decrements each cycle.
  - When the counter reaches 1, the next state is RESP.
- RESP:
  - oRespValid=1; oRespData and oRespErr are held stable until the handshake.
  - On iRespReady, the next state is IDLE and oRespValid=0 on the next cycle.
- Throughput and latency:
  - No back-to-back acceptance; maximum throughput is 1 request per (LATENCY+1) cycles when iRespReady is tied high.
  - Response latency is exactly LATENCY cycles after the acceptance edge.
- Address math:
  - offset = iReqAddr - BASE_ADDR (64-bit, unsigned wrap); index = offset[3 +: log2(DEPTH_WORDS)].
  - In range iff iReqAddr >= BASE_ADDR and offset < 8*DEPTH_WORDS.
  - Out-of-range write: no array change, oRespErr=1.
  - Out-of-range read: oRespData=0, oRespErr=1.
- Mask rules:
  - iReqMask=0 on a write is a legal no-op write with a normal response.
  - Mask is ignored for reads.
- Boundaries:
  - Request inputs are ignored in WAIT and RESP.
  - iReqValid may drop without acceptance; there is no state change.
  - Top word (BASE_ADDR+8*DEPTH_WORDS-8) is valid; the next word is an error.
  - iRst asserted mid-WAIT or mid-RESP aborts the transaction and drops the response. A write already committed stays committed.

Optional Feature:
- MEM_RESP_SRAM_TRACE_EN.
- When defined: on each accepted request, $display prints cycle count, R/W, address, data, mask and the in-range flag. An out-of-range access additionally prints "MEM ERR". The cycle counter is 64 bits, reset to 0.
- When undefined: no trace logic or counter is present; behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - localparam XLEN=64 and MASK_W=8.
  - Enum typedef for the FSM states {IDLE, WAIT, RESP}.
  - Response struct {data, err}.
  - Function apply_byte_mask(old, new, mask).
- One sub-module, mem_resp_sram_array: the register array with a synchronous masked write port and a read port sampled at acceptance. The responder FSM stays in the top module.

Test Plan:
- LATENCY=1, write addr 0x8000_0008, data 0x1122334455667788, mask 0xFF, then read the same address -> write response err=0, data=0; read response 1 cycle after acceptance with data 0x1122334455667788.
- Masked write to 0x8000_0008, data 0xAAAAAAAAAAAAAAAA, mask 0x0F, then read -> 0x11223344AAAAAAAA.
- LATENCY=3, read with iRespReady held 0 for 5 cycles -> oRespValid rises exactly 3 cycles after acceptance. Data stays stable while stalled. oReqReady=0 until 1 cycle after the response handshake.
- Read 0x7FFF_FFF8 and read BASE_ADDR+8*DEPTH_WORDS -> both oRespErr=1, data=0. Write to the top valid word, then read it -> err=0, data matches.
- Assert iRst during WAIT after a read request -> oRespValid never rises. After reset release, oReqReady=1 and a new read returns correct prior contents.
- iReqValid pulsed during WAIT/RESP with a different address -> ignored; only the first request's response is returned.
